// File: rtl/calc_seq.sv
// Program sequencer that drives the 8-bit queue calculator one (op, operand) instruction at a time.
// Optional single-step mode: define CALC_SEQ_STEP_EN to add the step input and the HOLD state.
module calc_seq #(
  parameter int DATA_W     = 8,
  parameter int OP_W       = 3,
  parameter int PROG_DEPTH = 16,
  localparam int AW        = $clog2(PROG_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
`ifdef CALC_SEQ_STEP_EN
  input  logic              step,
`endif
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [OP_W-1:0]   prog_op,
  input  logic [DATA_W-1:0] prog_data,
  input  logic [AW:0]       prog_len,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [AW-1:0]     err_pc,
  output logic [DATA_W-1:0] result,
  output logic              result_empty,
  output logic [DATA_W-1:0] calc_in,
  output logic [OP_W-1:0]   calc_op,
  output logic              calc_apply,
  output logic              calc_reset,
  input  logic [DATA_W-1:0] calc_tail,
  input  logic              calc_valid,
  input  logic              calc_empty
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    CHECK,
    DONE,
    ERR
`ifdef CALC_SEQ_STEP_EN
    , HOLD
`endif
  } state_t;

  state_t            state, state_next;
  logic [AW-1:0]     pc, pc_next;
  logic [AW:0]       len, len_next, len_sat;
  logic              last, err_set, res_set, res_zero, issue_next;

  logic [OP_W-1:0]   mem_op   [PROG_DEPTH];
  logic [DATA_W-1:0] mem_data [PROG_DEPTH];

  assign len_sat = (prog_len > (AW+1)'(PROG_DEPTH)) ? (AW+1)'(PROG_DEPTH) : prog_len;
  assign last    = ({1'b0, pc} == (len - (AW+1)'(1)));

  // Program memory is not reset and is frozen while a run owns the calculator.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) begin
      mem_op[prog_addr]   <= prog_op;
      mem_data[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    len_next   = len;
    err_set    = 1'b0;
    res_set    = 1'b0;
    res_zero   = 1'b0;
    case (state)
      IDLE, ERR: begin
        if (start) begin
          state_next = CLEAR;
          pc_next    = '0;
          len_next   = len_sat;
        end
      end
      CLEAR: begin
        if (len == '0) begin
          state_next = DONE;
          res_zero   = 1'b1;
        end else begin
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = CHECK;
      CHECK: begin
        if (!calc_valid) begin
          state_next = ERR;
          err_set    = 1'b1;
        end else if (last) begin
          state_next = DONE;
          res_set    = 1'b1;
        end else begin
          state_next = ISSUE;
          pc_next    = pc + AW'(1);
        end
      end
`ifdef CALC_SEQ_STEP_EN
      HOLD:    state_next = ISSUE;
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
`ifdef CALC_SEQ_STEP_EN
    // Every entry into ISSUE (from CLEAR, CHECK or HOLD) waits for a step pulse.
    if (state_next == ISSUE && !step) state_next = HOLD;
`endif
    issue_next = (state_next == ISSUE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= '0;
      len          <= '0;
      err_pc       <= '0;
      result       <= '0;
      result_empty <= 1'b1;
      calc_in      <= '0;
      calc_op      <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      len   <= len_next;
      if (err_set) err_pc <= pc;
      if (res_set) begin
        result       <= calc_tail;
        result_empty <= calc_empty;
      end else if (res_zero) begin
        result       <= '0;
        result_empty <= 1'b1;
      end
      if (issue_next) begin
        calc_op <= mem_op[pc_next];
        calc_in <= mem_data[pc_next];
      end
    end
  end

  assign done       = (state == DONE);
  assign error      = (state == ERR);
  assign busy       = !(state == IDLE || state == ERR);
  assign calc_apply = (state == ISSUE);
  assign calc_reset = reset || (state == CLEAR);

endmodule

// File: tb/tb_calc_seq.sv
// Bench for calc_seq: a behavioural queue-calculator stands in for the datapath, and a
// queue-based program interpreter predicts done/error, latency, err_pc and result.
module tb_calc_seq;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    int          n;
    logic [17:0] ops;   // op j in octal digit j
    logic [47:0] dat;   // operand j in byte j
    int          len;
    bit          exp_err;
    int          exp_pc;
    logic [7:0]  exp_res;
    bit          exp_emp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, prog_we, start, step;
  logic [3:0] prog_addr;
  logic [2:0] prog_op;
  logic [7:0] prog_data;
  logic [4:0] prog_len;
  logic       busy, done, error, result_empty;
  logic [3:0] err_pc;
  logic [7:0] result, calc_in, calc_tail;
  logic [2:0] calc_op;
  logic       calc_apply, calc_reset, calc_valid, calc_empty;

  int         n_cmp = 0, n_bad = 0;
  logic [2:0] sh_op [16];
  logic [7:0] sh_d  [16];
  logic [7:0] last_res = 8'd0;
  bit         last_emp = 1'b1;
  byte_q_t    cq;
  vec_t       tbl [9];

  always #5 clk = ~clk;

  calc_seq dut (
    .clk(clk), .reset(reset),
`ifdef CALC_SEQ_STEP_EN
    .step(step),
`endif
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_op(prog_op), .prog_data(prog_data),
    .prog_len(prog_len), .start(start), .busy(busy), .done(done), .error(error),
    .err_pc(err_pc), .result(result), .result_empty(result_empty),
    .calc_in(calc_in), .calc_op(calc_op), .calc_apply(calc_apply), .calc_reset(calc_reset),
    .calc_tail(calc_tail), .calc_valid(calc_valid), .calc_empty(calc_empty)
  );

  // Queue calculator semantics: capacity 5; binary ops take the two newest entries,
  // result = newer OP older; failure leaves the queue untouched.
  function automatic bit apply_op(input logic [2:0] op, input logic [7:0] v, inout byte_q_t q);
    logic [7:0] a, b, r;
    if (op == 3'd0) begin
      if (q.size() >= 5) return 1'b0;
      q.push_back(v);
      return 1'b1;
    end
    if (op == 3'd1) begin
      q.delete();
      return 1'b1;
    end
    if (op == 3'd7 || q.size() < 2) return 1'b0;
    a = q[q.size()-2];
    b = q[q.size()-1];
    if ((op == 3'd5 || op == 3'd6) && a == 8'd0) return 1'b0;
    case (op)
      3'd2:    r = a + b;
      3'd3:    r = a * b;
      3'd4:    r = b - a;
      3'd5:    r = b / a;
      default: r = b % a;
    endcase
    void'(q.pop_back());
    void'(q.pop_back());
    q.push_back(r);
    return 1'b1;
  endfunction

  // Calculator stand-in, updated mid-cycle from stable DUT outputs.
  initial begin
    calc_valid = 1'b1; calc_tail = 8'd0; calc_empty = 1'b1;
  end
  always @(negedge clk) begin
    if (calc_reset) begin
      cq.delete();
      calc_valid = 1'b1;
    end else if (calc_apply) begin
      calc_valid = apply_op(calc_op, calc_in, cq);
    end
    calc_tail  = (cq.size() > 0) ? cq[cq.size()-1] : 8'd0;
    calc_empty = (cq.size() == 0);
  end

  function automatic void ref_run(input int len, output bit err, output int epc,
                                  output logic [7:0] res, output bit emp);
    byte_q_t q;
    int n = (len > 16) ? 16 : len;
    err = 1'b0; epc = 0; res = 8'd0; emp = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (!apply_op(sh_op[i], sh_d[i], q)) begin
        err = 1'b1; epc = i;
        return;
      end
    end
    res = (q.size() > 0) ? q[q.size()-1] : 8'd0;
    emp = (q.size() == 0);
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, got, exp);
    end
  endtask

  task automatic write_mem(input int a, input logic [2:0] op, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = 4'(a); prog_op = op; prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
    sh_op[a] = op; sh_d[a] = d;
  endtask

  // Starts a run and follows it to done/error, checking latency and outputs.
  task automatic run_prog(input string tag, input int len, input bit exp_err, input int exp_pc,
                          input logic [7:0] exp_res, input bit exp_emp, input bit poke);
    int  edge_n = 0;
    bit  seen = 1'b0, s_done = 1'b0, s_err = 1'b0;
    int  eff = (len > 16) ? 16 : len;
    prog_len = 5'(len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 60 && !seen; e++) begin
      @(posedge clk); @(negedge clk);
      if (poke) prog_we = (e == 2);
      if (done || error) begin
        seen = 1'b1; edge_n = e; s_done = done; s_err = error;
      end
    end
    prog_we = 1'b0;
    check({tag, " outcome_error"}, 32'(s_err), 32'(exp_err));
    check({tag, " latency"}, edge_n, exp_err ? 2*exp_pc+3 : 2*eff+1);
    if (s_done) begin
      check({tag, " result"}, result, exp_res);
      check({tag, " result_empty"}, 32'(result_empty), 32'(exp_emp));
      last_res = exp_res; last_emp = exp_emp;
      @(posedge clk); @(negedge clk);
      check({tag, " done_pulse_end"}, {done, busy}, 0);
    end else if (s_err) begin
      check({tag, " err_pc"}, err_pc, exp_pc);
      check({tag, " busy_in_error"}, 32'(busy), 0);
      check({tag, " result_held"}, {result_empty, result}, {last_emp, last_res});
      @(posedge clk); @(negedge clk);
      check({tag, " error_held"}, 32'(error), 1);
    end
  endtask

  function automatic vec_t mk(int n, logic [17:0] ops, logic [47:0] dat, int len,
                              bit e, int pc, logic [7:0] r, bit emp);
    vec_t v;
    v.n = n; v.ops = ops; v.dat = dat; v.len = len;
    v.exp_err = e; v.exp_pc = pc; v.exp_res = r; v.exp_emp = emp;
    return v;
  endfunction

  initial begin
    bit         r_err, r_emp, quiet;
    int         r_pc, rlen;
    logic [7:0] r_res;
    logic [2:0] op;

    tbl[0] = mk(0, 18'o0,      48'h0,             0, 0, 0, 8'd0,  1);
    tbl[1] = mk(3, 18'o200,    48'h000000000404,  3, 0, 0, 8'd8,  0);
    tbl[2] = mk(3, 18'o500,    48'h000000005607,  3, 0, 0, 8'd12, 0);
    tbl[3] = mk(3, 18'o600,    48'h000000005607,  3, 0, 0, 8'd2,  0);
    tbl[4] = mk(3, 18'o500,    48'h000000005600,  3, 1, 2, 8'd0,  0);
    tbl[5] = mk(3, 18'o400,    48'h000000005607,  3, 0, 0, 8'd79, 0);
    tbl[6] = mk(6, 18'o000000, 48'h040404040404,  6, 1, 5, 8'd0,  0);
    tbl[7] = mk(2, 18'o10,     48'h000000000004,  2, 0, 0, 8'd0,  1);
    tbl[8] = mk(1, 18'o7,      48'h0,             1, 1, 0, 8'd0,  0);

    reset = 1'b1; prog_we = 1'b0; start = 1'b0; step = 1'b1;
    prog_addr = '0; prog_op = '0; prog_data = '0; prog_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("calc_reset_during_reset", 32'(calc_reset), 1);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_flags", {busy, done, error, calc_apply, calc_reset}, 0);
    check("reset_regs", {err_pc, result, result_empty, calc_in, calc_op}, {4'd0, 8'd0, 1'b1, 8'd0, 3'd0});

    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < tbl[i].n; j++)
        write_mem(j, tbl[i].ops[3*j +: 3], tbl[i].dat[8*j +: 8]);
      run_prog($sformatf("row%0d", i), tbl[i].len, tbl[i].exp_err, tbl[i].exp_pc,
               tbl[i].exp_res, tbl[i].exp_emp, 1'b0);
    end

    // Mid-run reset while instruction 1 is being issued.
    write_mem(0, 3'd0, 8'd4); write_mem(1, 3'd0, 8'd4); write_mem(2, 3'd2, 8'd0);
    prog_len = 5'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midrun calc_reset", 32'(calc_reset), 1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midrun abandoned", {busy, done, error}, 0);
    quiet = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || error || busy) quiet = 1'b0;
    end
    check("midrun stays idle", 32'(quiet), 1);
    check("midrun result_held", {result_empty, result}, {last_emp, last_res});
    run_prog("after_reset", 3, 0, 0, 8'd8, 0, 1'b0);

    // A write to addr 2 (mul) during the run must be dropped.
    prog_addr = 4'd2; prog_op = 3'd3; prog_data = 8'd0;
    run_prog("busy_write", 3, 0, 0, 8'd8, 0, 1'b1);
    run_prog("busy_write_rerun", 3, 0, 0, 8'd8, 0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      for (int j = 0; j < 16; j++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: op = 3'd0;
          6, 7, 8:          op = 3'($urandom_range(2, 6));
          default:          op = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'd1;
        endcase
        write_mem(j, op, 8'($urandom_range(0, 12)));
      end
      rlen = $urandom_range(0, 20);
      ref_run(rlen, r_err, r_pc, r_res, r_emp);
      run_prog($sformatf("rand%0d", r), rlen, r_err, r_pc, r_res, r_emp, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
